mem_access_unit: RTL and testbench

//  MEM-stage initiator for the word-wide data Memory block. It turns pipeline load/store requests
//  (lb/lbu/lh/lhu/lw/sb/sh/sw) into word accesses on the Memory port (A/WD/WE/MemToRegM -> RD).

---
 rtl/mem_access_unit_pkg.sv | 24 ++
 rtl/mem_lane_unit.sv | 42 ++++
 rtl/mem_access_unit.sv | 128 ++++++++++++
 tb/tb_mem_access_unit.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - shared size codes, FSM states and alignment helper
package mem_access_unit_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        MAU_IDLE     = 2'b00,
        MAU_LD_WAIT  = 2'b01,
        MAU_RMW_WAIT = 2'b10
    } mau_state_e;

    // Size 2'b11 is never legal, so it is reported alongside misalignment.
    function automatic logic bad_request(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SIZE_BYTE: bad_request = 1'b0;
            SIZE_HALF: bad_request = off[0];
            SIZE_WORD: bad_request = |off;
            default:   bad_request = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_unit.sv
// rtl/mem_lane_unit.sv - lane extraction/extension for loads and lane merge for sub-word stores
module mem_lane_unit
    import mem_access_unit_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic [31:0] rd,
    input  logic [31:0] wdata,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] load_word,
    output logic [31:0] store_word
);

    logic [1:0]  last_byte;
    logic [1:0]  shift_bytes;
    logic [4:0]  shamt;
    logic [31:0] lane_mask;
    logic [31:0] raw;

    always_comb begin
        case (size)
            SIZE_BYTE: begin last_byte = 2'd0; lane_mask = 32'h0000_00ff; end
            SIZE_HALF: begin last_byte = 2'd1; lane_mask = 32'h0000_ffff; end
            default:   begin last_byte = 2'd3; lane_mask = 32'hffff_ffff; end
        endcase
        // Big-endian puts byte offset 0 in the top lane, so count down from bit 31.
        shift_bytes = BIG_ENDIAN ? (2'd3 - last_byte - off) : off;
        shamt       = {shift_bytes, 3'b000};
        raw         = (rd >> shamt) & lane_mask;

        case (size)
            SIZE_BYTE: load_word = {{24{sign_ext & raw[7]}}, raw[7:0]};
            SIZE_HALF: load_word = {{16{sign_ext & raw[15]}}, raw[15:0]};
            default:   load_word = raw;
        endcase

        store_word = (rd & ~(lane_mask << shamt)) | ((wdata & lane_mask) << shamt);
    end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage initiator turning load/store requests into word memory accesses
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [1:0]  MemSizeM,
    input  logic        MemSignedM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        ReadValidM,
    output logic        StallM,
    output logic        ErrM,
    output logic [31:0] A,
    output logic [31:0] WD,
    output logic        WE,
    output logic        MemToRegM,
    input  logic [31:0] RD
);

    mau_state_e  state, next_state;
    logic [1:0]  off_q;
    logic [1:0]  size_q;
    logic        sign_q;
    logic [31:0] wdata_q;
    logic [31:0] a_q;
    logic [31:0] wd_q;
    logic [31:0] rdata_q;
    logic        req;
    logic        illegal;
    logic        accept;
    logic [31:0] load_word;
    logic [31:0] store_word;

    mem_lane_unit #(.BIG_ENDIAN(BIG_ENDIAN)) u_lane (
        .rd         (RD),
        .wdata      (wdata_q),
        .off        (off_q),
        .size       (size_q),
        .sign_ext   (sign_q),
        .load_word  (load_word),
        .store_word (store_word)
    );

    always_comb begin
        req     = MemReadM | MemWriteM;
        illegal = (MemReadM & MemWriteM) | bad_request(MemSizeM, ALUOutM[1:0]);
        accept  = !RST && (state == MAU_IDLE) && req && !illegal;
    end

    // A, WD and ReadDataM default to their held copies so they only move on real activity.
    always_comb begin
        next_state = state;
        A          = a_q;
        WD         = wd_q;
        ReadDataM  = rdata_q;
        WE         = 1'b0;
        MemToRegM  = 1'b0;
        StallM     = 1'b0;
        ReadValidM = 1'b0;
        ErrM       = 1'b0;
        if (!RST) begin
            case (state)
                MAU_IDLE: begin
                    if (req && illegal) begin
                        ErrM = 1'b1;
                    end else if (req) begin
                        A = {ALUOutM[31:2], 2'b00};
                        if (MemReadM) begin
                            MemToRegM  = 1'b1;
                            StallM     = 1'b1;
                            next_state = MAU_LD_WAIT;
                        end else if (MemSizeM == SIZE_WORD) begin
                            WE = 1'b1;
                            WD = WriteDataM;
                        end else begin
                            StallM     = 1'b1;
                            next_state = MAU_RMW_WAIT;
                        end
                    end
                end
                MAU_LD_WAIT: begin
                    ReadDataM  = load_word;
                    ReadValidM = 1'b1;
                    next_state = MAU_IDLE;
                end
                MAU_RMW_WAIT: begin
                    WE         = 1'b1;
                    WD         = store_word;
                    next_state = MAU_IDLE;
                end
                default: next_state = MAU_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= MAU_IDLE;
            a_q     <= 32'd0;
            wd_q    <= 32'd0;
            rdata_q <= 32'd0;
            off_q   <= 2'd0;
            size_q  <= SIZE_BYTE;
            sign_q  <= 1'b0;
            wdata_q <= 32'd0;
        end else begin
            state <= next_state;
            a_q   <= A;
            wd_q  <= WD;
            if (ReadValidM) begin
                rdata_q <= ReadDataM;
            end
            if (accept) begin
                off_q   <= ALUOutM[1:0];
                size_q  <= MemSizeM;
                sign_q  <= MemSignedM;
                wdata_q <= WriteDataM;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - bench for mem_access_unit against a byte-level reference memory
module tb_mem_access_unit;

    logic        CLK = 1'b0;
    logic        RST;
    logic        MemReadM;
    logic        MemWriteM;
    logic [1:0]  MemSizeM;
    logic        MemSignedM;
    logic [31:0] ALUOutM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;
    logic        ReadValidM;
    logic        StallM;
    logic        ErrM;
    logic [31:0] A;
    logic [31:0] WD;
    logic        WE;
    logic        MemToRegM;
    logic [31:0] RD;

    always #5 CLK = ~CLK;

    mem_access_unit #(.BIG_ENDIAN(1'b1)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .MemSizeM   (MemSizeM),
        .MemSignedM (MemSignedM),
        .ALUOutM    (ALUOutM),
        .WriteDataM (WriteDataM),
        .ReadDataM  (ReadDataM),
        .ReadValidM (ReadValidM),
        .StallM     (StallM),
        .ErrM       (ErrM),
        .A          (A),
        .WD         (WD),
        .WE         (WE),
        .MemToRegM  (MemToRegM),
        .RD         (RD)
    );

    // Word memory with registered read data, as seen by the unit.
    logic [31:0] mem [0:255];
    always @(posedge CLK) begin
        if (WE) mem[A[9:2]] <= WD;
        RD <= mem[A[9:2]];
    end

    // Reference: flat byte array, byte address order = big-endian significance.
    logic [7:0] ref_bytes [0:1023];

    int n_checks = 0;
    int n_fail   = 0;

    int          n_cyc;
    logic [7:0]  stall_hist;
    logic [7:0]  we_hist;
    logic        got_err;
    int          got_valid;
    logic [31:0] got_data;
    logic [31:0] a_first;
    logic        timed_out;

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [1:0] sz, input logic sg);
        int n = nbytes(sz);
        logic [31:0] v = 32'd0;
        for (int i = 0; i < n; i++) v = (v << 8) | {24'd0, ref_bytes[10'(addr[9:0] + 10'(i))]};
        if (sg && n == 1 && v[7])  v = v | 32'hffff_ff00;
        if (sg && n == 2 && v[15]) v = v | 32'hffff_0000;
        return v;
    endfunction

    task automatic ref_store(input logic [31:0] addr, input logic [1:0] sz, input logic [31:0] data);
        int n = nbytes(sz);
        for (int i = 0; i < n; i++) ref_bytes[10'(addr[9:0] + 10'(i))] = 8'(data >> (8 * (n - 1 - i)));
    endtask

    function automatic logic [31:0] ref_word(input logic [31:0] addr);
        logic [9:0] b = {addr[9:2], 2'b00};
        return {ref_bytes[b], ref_bytes[b + 10'd1], ref_bytes[b + 10'd2], ref_bytes[b + 10'd3]};
    endfunction

    task automatic idle_cycle();
        @(negedge CLK);
        MemReadM = 1'b0; MemWriteM = 1'b0; MemSizeM = 2'b00; MemSignedM = 1'b0;
    endtask

    // Drives one request and holds it while StallM is high; records per-cycle observations.
    task automatic run_op(input logic rd, input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [31:0] addr, input logic [31:0] wdat);
        @(negedge CLK);
        MemReadM = rd; MemWriteM = wr; MemSizeM = sz; MemSignedM = sg;
        ALUOutM = addr; WriteDataM = wdat;
        n_cyc = 0; stall_hist = '0; we_hist = '0; got_err = 1'b0;
        got_valid = 0; got_data = 32'd0; a_first = 32'd0; timed_out = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge CLK);
            #1;
            stall_hist[c] = StallM;
            we_hist[c]    = WE;
            if (ErrM) got_err = 1'b1;
            if (c == 0) a_first = A;
            if (ReadValidM) begin
                got_valid++;
                got_data = ReadDataM;
            end
            n_cyc = c + 1;
            if (!StallM) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        RST = 1'b1; MemReadM = 1'b1; MemWriteM = 1'b0; MemSizeM = 2'b10; MemSignedM = 1'b0;
        ALUOutM = 32'h404; WriteDataM = 32'd0;
        repeat (2) @(negedge CLK);
        #1;
        n_checks++;
        if ({WE, MemToRegM, StallM, ReadValidM, ErrM} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 00000", {WE, MemToRegM, StallM, ReadValidM, ErrM});
        end
        @(negedge CLK);
        RST = 1'b0; MemReadM = 1'b0;
        #1;
        n_checks++;
        if (A !== 32'd0 || WD !== 32'd0 || ReadDataM !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_regs: got A=%h WD=%h RDM=%h expected all 0", A, WD, ReadDataM);
        end
    endtask

    task automatic test_word_rw();
        run_op(1'b0, 1'b1, 2'b10, 1'b0, 32'h404, 32'hDEADBEEF);
        ref_store(32'h404, 2'b10, 32'hDEADBEEF);
        n_checks++;
        if (n_cyc != 1 || stall_hist[0] !== 1'b0 || we_hist[0] !== 1'b1 || a_first !== 32'h404) begin
            n_fail++;
            $display("FAIL sw_timing: got cyc=%0d stall=%b we=%b A=%h expected 1 0 1 00000404",
                     n_cyc, stall_hist[0], we_hist[0], a_first);
        end
        run_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h404, 32'd0);
        n_checks++;
        if (n_cyc != 2 || stall_hist[1:0] !== 2'b01 || got_valid != 1 || timed_out) begin
            n_fail++;
            $display("FAIL lw_timing: got cyc=%0d stall=%b valid=%0d expected 2 01 1", n_cyc, stall_hist[1:0], got_valid);
        end
        n_checks++;
        if (got_data !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL lw_data: got %h expected deadbeef", got_data);
        end
        idle_cycle();
    endtask

    task automatic test_load_ext();
        logic [1:0]  sz  [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
        logic        sg  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] ad  [4] = '{32'h405, 32'h405, 32'h406, 32'h404};
        logic [31:0] exp [4] = '{32'hFFFFFFAD, 32'h000000AD, 32'hFFFFBEEF, 32'h0000DEAD};
        for (int i = 0; i < 4; i++) begin
            run_op(1'b1, 1'b0, sz[i], sg[i], ad[i], 32'd0);
            n_checks++;
            if (got_data !== exp[i] || got_valid != 1 || n_cyc != 2) begin
                n_fail++;
                $display("FAIL load_ext[%0d]: got %h (valid=%0d cyc=%0d) expected %h", i, got_data, got_valid, n_cyc, exp[i]);
            end
        end
        idle_cycle();
    endtask

    task automatic test_subword_store();
        run_op(1'b0, 1'b1, 2'b10, 1'b0, 32'h408, 32'h11223344);
        ref_store(32'h408, 2'b10, 32'h11223344);
        run_op(1'b0, 1'b1, 2'b00, 1'b0, 32'h40A, 32'h000000AA);
        ref_store(32'h40A, 2'b00, 32'h000000AA);
        n_checks++;
        if (n_cyc != 2 || stall_hist[1:0] !== 2'b01 || we_hist[1:0] !== 2'b10) begin
            n_fail++;
            $display("FAIL sb_timing: got cyc=%0d stall=%b we=%b expected 2 01 10", n_cyc, stall_hist[1:0], we_hist[1:0]);
        end
        idle_cycle();
        n_checks++;
        if (mem[8'h02] !== 32'h1122AA44) begin
            n_fail++;
            $display("FAIL sb_merge: got %h expected 1122aa44", mem[8'h02]);
        end
        run_op(1'b0, 1'b1, 2'b01, 1'b0, 32'h408, 32'h0000BBCC);
        ref_store(32'h408, 2'b01, 32'h0000BBCC);
        n_checks++;
        if (n_cyc != 2 || stall_hist[1:0] !== 2'b01 || we_hist[1:0] !== 2'b10) begin
            n_fail++;
            $display("FAIL sh_timing: got cyc=%0d stall=%b we=%b expected 2 01 10", n_cyc, stall_hist[1:0], we_hist[1:0]);
        end
        idle_cycle();
        n_checks++;
        if (mem[8'h02] !== 32'hBBCCAA44) begin
            n_fail++;
            $display("FAIL sh_merge: got %h expected bbccaa44", mem[8'h02]);
        end
    endtask

    task automatic test_errors();
        logic        rdv [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic        wrv [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [1:0]  szv [4] = '{2'b10, 2'b01, 2'b10, 2'b11};
        logic [31:0] adv [4] = '{32'h402, 32'h401, 32'h404, 32'h404};
        run_op(1'b0, 1'b1, 2'b10, 1'b0, 32'h400, 32'h01020304);
        ref_store(32'h400, 2'b10, 32'h01020304);
        run_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h404, 32'd0);
        for (int i = 0; i < 4; i++) begin
            run_op(rdv[i], wrv[i], szv[i], 1'b0, adv[i], 32'h55555555);
            n_checks++;
            if (!got_err || n_cyc != 1 || stall_hist[0] !== 1'b0 || we_hist[0] !== 1'b0 || a_first !== 32'h404) begin
                n_fail++;
                $display("FAIL err[%0d]: got err=%b cyc=%0d stall=%b we=%b A=%h expected 1 1 0 0 00000404",
                         i, got_err, n_cyc, stall_hist[0], we_hist[0], a_first);
            end
            idle_cycle();
            n_checks++;
            if (mem[adv[i][9:2]] !== ref_word(adv[i])) begin
                n_fail++;
                $display("FAIL err_mem[%0d]: got %h expected %h", i, mem[adv[i][9:2]], ref_word(adv[i]));
            end
        end
    endtask

    task automatic test_reset_rmw();
        run_op(1'b0, 1'b1, 2'b10, 1'b0, 32'h410, 32'h55667788);
        ref_store(32'h410, 2'b10, 32'h55667788);
        @(negedge CLK);
        MemReadM = 1'b0; MemWriteM = 1'b1; MemSizeM = 2'b00; ALUOutM = 32'h411; WriteDataM = 32'h99;
        #1;
        n_checks++;
        if (StallM !== 1'b1) begin
            n_fail++;
            $display("FAIL rmw_stall: got %b expected 1", StallM);
        end
        @(negedge CLK);
        RST = 1'b1; MemWriteM = 1'b0;
        #1;
        n_checks++;
        if (WE !== 1'b0 || ReadValidM !== 1'b0 || StallM !== 1'b0) begin
            n_fail++;
            $display("FAIL rmw_reset: got WE=%b RV=%b stall=%b expected 0 0 0", WE, ReadValidM, StallM);
        end
        @(negedge CLK);
        RST = 1'b0;
        #1;
        n_checks++;
        if (WE !== 1'b0 || StallM !== 1'b0 || mem[8'h04] !== 32'h55667788) begin
            n_fail++;
            $display("FAIL rmw_dropped: got WE=%b stall=%b mem=%h expected 0 0 55667788", WE, StallM, mem[8'h04]);
        end
        run_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h410, 32'd0);
        n_checks++;
        if (got_data !== 32'h55667788 || n_cyc != 2 || got_valid != 1) begin
            n_fail++;
            $display("FAIL rmw_after_lw: got %h cyc=%0d expected 55667788 2", got_data, n_cyc);
        end
        idle_cycle();
    endtask

    task automatic test_back_to_back();
        logic [5:0]  pat = '0;
        int          total = 0;
        logic [31:0] first_lw;
        run_op(1'b0, 1'b1, 2'b10, 1'b0, 32'h40C, 32'hA1B2C3D4);
        ref_store(32'h40C, 2'b10, 32'hA1B2C3D4);
        run_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h40C, 32'd0);
        first_lw = got_data;
        for (int c = 0; c < n_cyc; c++) pat = {pat[4:0], stall_hist[c]};
        total += n_cyc;
        run_op(1'b0, 1'b1, 2'b00, 1'b0, 32'h40D, 32'h000000EE);
        ref_store(32'h40D, 2'b00, 32'h000000EE);
        for (int c = 0; c < n_cyc; c++) pat = {pat[4:0], stall_hist[c]};
        total += n_cyc;
        run_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h40C, 32'd0);
        for (int c = 0; c < n_cyc; c++) pat = {pat[4:0], stall_hist[c]};
        total += n_cyc;
        n_checks++;
        if (first_lw !== 32'hA1B2C3D4 || got_data !== 32'hA1EEC3D4) begin
            n_fail++;
            $display("FAIL b2b_data: got %h,%h expected a1b2c3d4,a1eec3d4", first_lw, got_data);
        end
        n_checks++;
        if (total != 6 || pat !== 6'b101010) begin
            n_fail++;
            $display("FAIL b2b_stall: got total=%0d pattern=%b expected 6 101010", total, pat);
        end
        idle_cycle();
    endtask

    task automatic test_random();
        int errs = 0;
        for (int w = 0; w < 64; w++) begin
            logic [31:0] d = $urandom;
            run_op(1'b0, 1'b1, 2'b10, 1'b0, 32'h400 + 32'(4 * w), d);
            ref_store(32'h400 + 32'(4 * w), 2'b10, d);
        end
        for (int k = 0; k < 120; k++) begin
            int          op  = $urandom_range(0, 7);
            logic [1:0]  sz  = (op == 0 || op == 1 || op == 5) ? 2'b00 : (op == 2 || op == 3 || op == 6) ? 2'b01 : 2'b10;
            logic        sg  = (op == 0 || op == 2);
            logic        ld  = (op < 5);
            logic [31:0] ad  = 32'h400 | 32'($urandom_range(0, 255));
            logic [31:0] wd  = $urandom;
            logic        bad;
            logic [31:0] exp;
            int          exp_cyc;
            if ($urandom_range(0, 3) != 0) ad = ad & ~32'(nbytes(sz) - 1);
            bad     = (ad % nbytes(sz)) != 0;
            exp     = ref_load(ad, sz, sg);
            exp_cyc = (bad || (!ld && sz == 2'b10)) ? 1 : 2;
            run_op(ld, !ld, sz, sg, ad, wd);
            if (!ld && !bad) ref_store(ad, sz, wd);
            n_checks++;
            if (got_err !== bad || n_cyc != exp_cyc || timed_out) begin
                n_fail++;
                $display("FAIL rand_ctrl[%0d]: got err=%b cyc=%0d expected %b %0d (op=%0d addr=%h)",
                         k, got_err, n_cyc, bad, exp_cyc, op, ad);
            end
            if (ld && !bad) begin
                n_checks++;
                if (got_valid != 1 || got_data !== exp) begin
                    n_fail++;
                    $display("FAIL rand_load[%0d]: got %h valid=%0d expected %h (op=%0d addr=%h)",
                             k, got_data, got_valid, exp, op, ad);
                end
            end
        end
        idle_cycle();
        for (int w = 0; w < 64; w++) begin
            if (mem[8'(w)] !== ref_word(32'h400 + 32'(4 * w))) errs++;
        end
        n_checks++;
        if (errs != 0) begin
            n_fail++;
            $display("FAIL rand_mem: got %0d differing words expected 0", errs);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; MemReadM = 1'b0; MemWriteM = 1'b0; MemSizeM = 2'b00; MemSignedM = 1'b0;
        ALUOutM = 32'd0; WriteDataM = 32'd0;
        test_reset();
        test_word_rw();
        test_load_ext();
        test_subword_store();
        test_errors();
        test_reset_rmw();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
